wave_i2s_tx: RTL and testbench
==============================

Name: wave_i2s_tx

Overview:
- Downstream stage of the waveform generator; serialises its 24-bit sample stream to the board audio DAC.
- Frames are I2S (Philips). The mono sample is sent identically on left and right.
- Input side uses a one-deep valid/ready holding register. BCLK and LRCK are derived from i_clk by an internal divider.
- One new sample is consumed per LRCK frame. Underruns repeat the last sample and are flagged.

Parameters:
- DATA_WIDTH, 24, sample width; must be ≤ SLOT_WIDTH-1.
- SLOT_WIDTH, 32, BCLK periods per channel slot.
- BCLK_DIV, 4, i_clk cycles per BCLK half-period; must be ≥ 2.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous active-low reset.
- i_sample  in  DATA_WIDTH  two's-complement sample from the wave generator.
- i_sample_valid  in  1  i_sample is valid this cycle.
- o_sample_ready  out  1  holding register empty; transfer occurs when valid && ready.
- o_bclk  out  1  serial bit clock.
- o_lrck  out  1  word select; 0 = left, 1 = right.
- o_dacdat  out  1  serial data, MSB first.
- o_frame_start  out  1  one-cycle pulse when a new frame's data is loaded.
- o_underrun  out  1  one-cycle pulse when a frame starts with the holding register empty.

Behaviour:
- Reset (i_rst=0 at a clock edge): o_bclk=0, o_lrck=0, o_dacdat=0, o_sample_ready=1, o_frame_start=0, o_underrun=0. Holding register empty; last_sample=0; div_cnt=0; bit_cnt=2*SLOT_WIDTH-1. Reset mid-frame aborts the frame immediately; no partial-frame completion.
- Divider: div_cnt counts 0..BCLK_DIV-1 and wraps. At wrap, o_bclk toggles, giving a BCLK period of 2*BCLK_DIV clocks.
  - fall_tick: the cycle in which o_bclk goes 1→0.
  - rise_tick: the cycle in which o_bclk goes 0→1.
- Bit counter: on each fall_tick, bit_cnt increments modulo 2*SLOT_WIDTH.
- o_lrck updates on fall_tick: 0 when the new bit_cnt < SLOT_WIDTH, else 1.
- Frame start is the fall_tick where bit_cnt wraps to 0. On that tick:
  - If the holding register is full: shift source ← held sample; last_sample ← held sample; register marked empty.
  - If empty: shift source ← last_sample and o_underrun pulses.
  - o_frame_start pulses in the same cycle.
- Data: on each fall_tick, o_dacdat = bit (DATA_WIDTH-1 - (s-1)) of the shift source, where s = bit_cnt mod SLOT_WIDTH and 1 ≤ s ≤ DATA_WIDTH. Otherwise o_dacdat = 0. This gives the I2S one-BCLK delay after each LRCK edge; the right slot repeats the left data.
- DAC samples o_dacdat on the BCLK rising edge; o_dacdat and o_lrck are stable for the full BCLK period.
- Handshake:
  - o_sample_ready = !full, registered.
  - A transfer in cycle t sets full at t+1, so o_sample_ready drops at t+1.
  - i_sample is ignored while ready=0; the held value must not change.
  - Simultaneous frame-start consume and new transfer: impossible in the same cycle, because ready is 0 while full.
  - A transfer in the cycle after consume is accepted.
- Latency: a sample accepted before frame start F appears with its MSB on o_dacdat one BCLK after F, on both slots.
- Output from first frame after reset = 0 (last_sample reset value) with o_underrun pulse unless a sample was accepted first.

Optional Feature:
- Macro I2S_LEFT_JUSTIFY_EN. When defined, the format is left-justified: the MSB is driven in the same fall_tick as the LRCK edge. Bit index uses s instead of s-1 for 0 ≤ s ≤ DATA_WIDTH-1, and the remaining bits are 0. DATA_WIDTH ≤ SLOT_WIDTH is then allowed.
- When undefined, standard I2S with the one-BCLK delay, as above. All other timing is identical.

Test Plan:
- Reset, then present 24'hA50F3C with valid held high. Ready drops 1 cycle after the transfer. Bench captures o_dacdat on o_bclk rising edges and decodes left = right = 24'hA50F3C, bits 25..31 of each slot = 0. o_lrck period = 64 BCLK = 512 clocks (defaults).
- No sample after the first frame: next frame repeats 24'hA50F3C; o_underrun pulses exactly once per starved frame, coincident with o_frame_start.
- Stream 24'h7FFFFF, 24'h800000, 24'h000001 via valid/ready with random valid gaps. Three consecutive frames carry the values in order; zero underruns; no sample dropped or duplicated; the held value is stable while ready=0 even with i_sample changing.
- Assert i_rst=0 mid-right-slot (bit_cnt≈40). Next clock: all outputs at reset values, ready=1. After release, the first frame outputs 0 with an underrun pulse, and the LRCK/BCLK phase restarts cleanly.
- With I2S_LEFT_JUSTIFY_EN defined, send 24'hC00001: MSB=1 sampled on the first BCLK rise after each LRCK edge and the LSB at slot bit 23. Without the macro, the same bits are shifted by one BCLK.

Source files
------------

// File: rtl/wave_i2s_tx.sv
// I2S serialiser for the waveform generator: one-deep valid/ready holding register,
// internal BCLK/LRCK divider, mono sample repeated on both slots, underrun flagging.
// Define I2S_LEFT_JUSTIFY_EN to switch to left-justified framing (no one-BCLK delay).
module wave_i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic                  i_sample_valid,
  output logic                  o_sample_ready,
  output logic                  o_bclk,
  output logic                  o_lrck,
  output logic                  o_dacdat,
  output logic                  o_frame_start,
  output logic                  o_underrun
);

  localparam int DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int SLOT_W = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(BCLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SLOT_WIDTH - 1);
`ifdef I2S_LEFT_JUSTIFY_EN
  localparam logic [SLOT_W-1:0] LAST_BIT = SLOT_W'(DATA_WIDTH - 1);
`else
  localparam logic [SLOT_W-1:0] LAST_BIT = SLOT_W'(DATA_WIDTH);
`endif

  logic [DIV_W-1:0]      div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic                  side_q, side_d;
  logic                  lrck_q, lrck_d;
  logic                  dac_q, dac_d;
  logic                  fs_q, fs_d;
  logic                  ur_q, ur_d;
  logic                  full_q, full_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;

  logic tick, fall, xfer, slot_wrap;

  always_comb begin
    div_d     = div_q + 1'b1;
    bclk_d    = bclk_q;
    slot_d    = slot_q;
    side_d    = side_q;
    lrck_d    = lrck_q;
    dac_d     = dac_q;
    fs_d      = 1'b0;
    ur_d      = 1'b0;
    full_d    = full_q;
    hold_d    = hold_q;
    last_d    = last_q;
    sreg_d    = sreg_q;
    slot_wrap = 1'b0;

    tick = (div_q == DIV_MAX);
    fall = tick & bclk_q;
    xfer = i_sample_valid & ready_q;

    if (tick) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end

    // ready is only high while empty, so a transfer never collides with a consume
    if (xfer) begin
      hold_d = i_sample;
      full_d = 1'b1;
    end

    if (fall) begin
      slot_wrap = (slot_q == SLOT_MAX);
      slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
      if (slot_wrap) side_d = ~side_q;
      lrck_d = side_d;

      if (slot_wrap && side_q) begin
        fs_d = 1'b1;
        if (full_q) begin
          last_d = hold_q;
          full_d = 1'b0;
        end else begin
          ur_d = 1'b1;
        end
      end

      // each slot reloads from the frame sample so the right slot repeats the left
      dac_d = 1'b0;
      if (slot_d == '0) begin
`ifdef I2S_LEFT_JUSTIFY_EN
        dac_d  = last_d[DATA_WIDTH-1];
        sreg_d = {last_d[DATA_WIDTH-2:0], 1'b0};
`else
        sreg_d = last_d;
`endif
      end else if (slot_d <= LAST_BIT) begin
        dac_d  = sreg_q[DATA_WIDTH-1];
        sreg_d = {sreg_q[DATA_WIDTH-2:0], 1'b0};
      end
    end

    ready_d = ~full_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      slot_q  <= SLOT_MAX;
      side_q  <= 1'b1;
      lrck_q  <= 1'b0;
      dac_q   <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      hold_q  <= '0;
      last_q  <= '0;
      sreg_q  <= '0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      slot_q  <= slot_d;
      side_q  <= side_d;
      lrck_q  <= lrck_d;
      dac_q   <= dac_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      sreg_q  <= sreg_d;
    end
  end

  assign o_sample_ready = ready_q;
  assign o_bclk         = bclk_q;
  assign o_lrck         = lrck_q;
  assign o_dacdat       = dac_q;
  assign o_frame_start  = fs_q;
  assign o_underrun     = ur_q;

endmodule

// File: tb/tb_wave_i2s_tx.sv
// Bench for wave_i2s_tx: closed-form timing model checked every cycle, plus a
// frame table decoded from o_dacdat on BCLK rising edges.
module tb_wave_i2s_tx;
  localparam int DW = 24;
  localparam int SW = 32;
  localparam int D  = 4;
  localparam int NT = 9;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [DW-1:0] i_sample = '0;
  logic          i_sample_valid = 1'b0;
  logic          o_sample_ready, o_bclk, o_lrck, o_dacdat, o_frame_start, o_underrun;

  always #5 i_clk = ~i_clk;

  wave_i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(D)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sample(i_sample), .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready), .o_bclk(o_bclk), .o_lrck(o_lrck),
    .o_dacdat(o_dacdat), .o_frame_start(o_frame_start), .o_underrun(o_underrun)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int            k = 0;
  int            m_b = -1;
  int            m_frames = 0;
  logic          m_full = 1'b0;
  logic          m_xfer = 1'b0;
  logic [DW-1:0] m_hold = '0;
  logic [DW-1:0] m_last = '0;
  logic          e_bclk = 1'b0, e_lrck = 1'b0, e_dac = 1'b0, e_ready = 1'b1, e_fs = 1'b0, e_ur = 1'b0;

  // decoder state
  logic [63:0] cap = '0;
  logic        prev_bclk = 1'b0;
  logic [31:0] dec_l[$];
  logic [31:0] dec_r[$];
  logic        dut_ur[$];

  typedef struct {
    logic          has;
    logic [DW-1:0] smp;
    logic [31:0]   word;
    logic          ur;
  } vec_t;
  vec_t tbl[NT];

  function automatic logic [31:0] exp_word(input logic [DW-1:0] s);
`ifdef I2S_LEFT_JUSTIFY_EN
    return {s, 8'h00};
`else
    return {1'b0, s, 7'h00};
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs as a function of edges since reset: BCLK toggles every D
  // edges, every 2*D-th edge is a falling BCLK that advances the frame bit.
  task automatic model_edge(input logic rst, input logic vld, input logic [DW-1:0] smp);
    int s;
    logic [4:0] idx;
    e_fs = 1'b0;
    e_ur = 1'b0;
    m_xfer = 1'b0;
    if (!rst) begin
      k = 0; m_b = -1; m_full = 1'b0; m_hold = '0; m_last = '0;
      e_bclk = 1'b0; e_lrck = 1'b0; e_dac = 1'b0; e_ready = 1'b1;
    end else begin
      k++;
      m_xfer = vld && !m_full;
      e_bclk = ((k / D) % 2) == 1;
      if (k % (2 * D) == 0) begin
        m_b = (k / (2 * D) - 1) % (2 * SW);
        if (m_b == 0) begin
          e_fs = 1'b1;
          m_frames++;
          if (m_full) begin
            m_last = m_hold;
            m_full = 1'b0;
          end else begin
            e_ur = 1'b1;
          end
        end
        e_lrck = (m_b >= SW);
        s = m_b % SW;
        e_dac = 1'b0;
`ifdef I2S_LEFT_JUSTIFY_EN
        if (s <= DW - 1) begin idx = 5'(DW - 1 - s); e_dac = m_last[idx]; end
`else
        if (s >= 1 && s <= DW) begin idx = 5'(DW - s); e_dac = m_last[idx]; end
`endif
      end
      if (m_xfer) begin
        m_full = 1'b1;
        m_hold = smp;
      end
      e_ready = !m_full;
    end
  endtask

  task automatic step(input logic rst, input logic vld, input logic [DW-1:0] smp);
    i_rst = rst;
    i_sample_valid = vld;
    i_sample = smp;
    @(posedge i_clk);
    model_edge(rst, vld, smp);
    #1;
    chk("outputs{bclk,lrck,dac,ready,fs,ur}",
        64'({o_bclk, o_lrck, o_dacdat, o_sample_ready, o_frame_start, o_underrun}),
        64'({e_bclk, e_lrck, e_dac, e_ready, e_fs, e_ur}));
    if (o_frame_start) dut_ur.push_back(o_underrun);
    if (!rst) begin
      prev_bclk = 1'b0;
      cap = '0;
    end else begin
      if (o_bclk && !prev_bclk && m_b >= 0) begin
        cap[6'(63 - m_b)] = o_dacdat;
        if (m_b == 2 * SW - 1) begin
          dec_l.push_back(cap[63:32]);
          dec_r.push_back(cap[31:0]);
        end
      end
      prev_bclk = o_bclk;
    end
  endtask

  task automatic send(input logic [DW-1:0] smp);
    int cnt = 0;
    m_xfer = 1'b0;
    while (!m_xfer && cnt < 100) begin
      step(1'b1, 1'b1, smp);
      cnt++;
    end
    if (!m_xfer) chk("send_timeout", 64'(cnt), 64'(0));
    else chk("ready_drop", 64'(o_sample_ready), 64'(0));
  endtask

  // keeps valid high with changing data while the register is full
  task automatic wait_frames(input int n);
    int cnt = 0;
    while (m_frames < n && cnt < 3000) begin
      step(1'b1, m_full, DW'($urandom));
      cnt++;
    end
    if (m_frames < n) chk("frame_wait_timeout", 64'(m_frames), 64'(n));
  endtask

  initial begin
    int gap, cnt, base_d, base_u;
    logic [DW-1:0] r0, r1;
    r0 = DW'($urandom);
    r1 = DW'($urandom);
`ifdef I2S_LEFT_JUSTIFY_EN
    tbl[0] = '{1'b1, 24'hA50F3C, 32'hA50F3C00, 1'b0};
    tbl[1] = '{1'b0, 24'h000000, 32'hA50F3C00, 1'b1};
    tbl[2] = '{1'b1, 24'h7FFFFF, 32'h7FFFFF00, 1'b0};
    tbl[3] = '{1'b1, 24'h800000, 32'h80000000, 1'b0};
    tbl[4] = '{1'b1, 24'h000001, 32'h00000100, 1'b0};
    tbl[5] = '{1'b1, 24'hC00001, 32'hC0000100, 1'b0};
`else
    tbl[0] = '{1'b1, 24'hA50F3C, 32'h52879E00, 1'b0};
    tbl[1] = '{1'b0, 24'h000000, 32'h52879E00, 1'b1};
    tbl[2] = '{1'b1, 24'h7FFFFF, 32'h3FFFFF80, 1'b0};
    tbl[3] = '{1'b1, 24'h800000, 32'h40000000, 1'b0};
    tbl[4] = '{1'b1, 24'h000001, 32'h00000080, 1'b0};
    tbl[5] = '{1'b1, 24'hC00001, 32'h60000080, 1'b0};
`endif
    tbl[6] = '{1'b1, r0, exp_word(r0), 1'b0};
    tbl[7] = '{1'b1, r1, exp_word(r1), 1'b0};
    tbl[8] = '{1'b0, 24'h000000, exp_word(r1), 1'b1};

    repeat (3) step(1'b0, 1'b0, '0);
    chk("reset_ready", 64'(o_sample_ready), 64'(1));
    chk("reset_outs", 64'({o_bclk, o_lrck, o_dacdat, o_frame_start, o_underrun}), 64'(0));

    for (int i = 0; i < NT; i++) begin
      if (tbl[i].has) begin
        gap = (i == 0) ? 0 : int'($urandom_range(0, 20));
        repeat (gap) step(1'b1, 1'b0, DW'($urandom));
        send(tbl[i].smp);
      end
      wait_frames(i + 1);
    end

    cnt = 0;
    while (dec_l.size() < NT && cnt < 1200) begin
      step(1'b1, 1'b0, DW'($urandom));
      cnt++;
    end
    for (int i = 0; i < NT; i++) begin
      if (i < dec_l.size()) begin
        chk($sformatf("frame%0d_left", i), 64'(dec_l[i]), 64'(tbl[i].word));
        chk($sformatf("frame%0d_right", i), 64'(dec_r[i]), 64'(tbl[i].word));
      end else begin
        chk($sformatf("frame%0d_decoded", i), 64'(dec_l.size()), 64'(i + 1));
      end
      if (i < dut_ur.size()) chk($sformatf("frame%0d_underrun", i), 64'(dut_ur[i]), 64'(tbl[i].ur));
      else chk($sformatf("frame%0d_started", i), 64'(dut_ur.size()), 64'(i + 1));
    end

    // reset in the middle of the right slot
    cnt = 0;
    while (m_b != 40 && cnt < 700) begin
      step(1'b1, 1'b0, DW'($urandom));
      cnt++;
    end
    chk("reach_bit40", 64'(m_b), 64'(40));
    step(1'b0, 1'b1, DW'($urandom));
    chk("midreset_ready", 64'(o_sample_ready), 64'(1));
    chk("midreset_outs", 64'({o_bclk, o_lrck, o_dacdat, o_frame_start, o_underrun}), 64'(0));
    base_d = dec_l.size();
    base_u = dut_ur.size();
    cnt = 0;
    while (dec_l.size() <= base_d && cnt < 1200) begin
      step(1'b1, 1'b0, DW'($urandom));
      cnt++;
    end
    if (dec_l.size() > base_d) begin
      chk("post_reset_left", 64'(dec_l[base_d]), 64'(0));
      chk("post_reset_right", 64'(dec_r[base_d]), 64'(0));
    end else begin
      chk("post_reset_decoded", 64'(dec_l.size()), 64'(base_d + 1));
    end
    if (dut_ur.size() > base_u) chk("post_reset_underrun", 64'(dut_ur[base_u]), 64'(1));
    else chk("post_reset_started", 64'(dut_ur.size()), 64'(base_u + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
